// File: rtl/hex_scroller_pkg.sv
// Shared constants, state type and symbol lookup for the hex scroller.
package hex_scroller_pkg;

   localparam logic [4:0] BLANK = 5'd23;
   localparam logic [4:0] SEG_G = 5'd22;

   localparam int unsigned TICK_CNT_HW  = 25_000_000;
   localparam int unsigned TICK_CNT_SIM = 4;

   typedef enum logic [1:0] {
      IDLE,
      SCROLL,
      HOLD,
      SHOW
   } state_t;

   // Symbol i of the scroll sequence: four blanks, then nibble 7 down to nibble 0.
   function automatic logic [4:0] sym(input logic [31:0] data, input logic [3:0] idx);
      logic [31:0] w_sh;
      if (idx < 4'd4) begin
         return BLANK;
      end
      w_sh = data >> {4'(4'd11 - idx), 2'b00};
      return {1'b0, w_sh[3:0]};
   endfunction

endpackage

// File: rtl/hex_scroller_tick_gen.sv
// Free-running period counter producing a one-cycle tick while enabled.
module tick_gen
   import hex_scroller_pkg::*;
#(
   parameter int unsigned PERIOD = TICK_CNT_SIM
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

   logic [CW-1:0] r_cnt;

   // Count while enabled, wrapping after the last count of the period.
   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
      end
   end

   assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/hex_scroller.sv
// Scrolls a 32-bit word across a four-digit display, holds the final window,
// then stops or repeats.
module hex_scroller
   import hex_scroller_pkg::*;
#(
   parameter int unsigned SIMULATE   = 0,
   parameter int unsigned HOLD_TICKS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data_in,
   input  logic        load,
   input  logic        repeat_en,
   output logic        busy,
   output logic        done,
   output logic [4:0]  d3,
   output logic [4:0]  d2,
   output logic [4:0]  d1,
   output logic [4:0]  d0,
   output logic [3:0]  dp
);

   localparam int unsigned TICK_CNT = (SIMULATE != 0) ? TICK_CNT_SIM : TICK_CNT_HW;
   localparam int unsigned HW       = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

   state_t        r_state, w_state_nx;
   logic [3:0]    r_p, w_p_nx;
   logic [HW-1:0] r_hold, w_hold_nx;
   logic [31:0]   r_data, w_data_nx;
   logic          w_done_nx;
   logic          w_accept;
   logic          w_run;
   logic          w_tick;

   assign w_run = (r_state == SCROLL) || (r_state == HOLD);

   tick_gen #(.PERIOD(TICK_CNT)) u_tick (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_run),
      .i_clr  (w_accept),
      .o_tick (w_tick)
   );

   // Next-state logic: load acceptance, scroll advance and hold completion.
   always_comb begin
      w_state_nx = r_state;
      w_p_nx     = r_p;
      w_hold_nx  = r_hold;
      w_data_nx  = r_data;
      w_done_nx  = 1'b0;
      w_accept   = 1'b0;
      case (r_state)
         IDLE, SHOW: begin
            if (load) begin
               w_accept   = 1'b1;
               w_data_nx  = data_in;
               w_p_nx     = 4'd0;
               w_hold_nx  = '0;
               w_state_nx = SCROLL;
            end
         end
         SCROLL: begin
            if (w_tick) begin
               w_p_nx = r_p + 4'd1;
               if (r_p == 4'd7) begin
                  w_hold_nx  = '0;
                  w_state_nx = HOLD;
               end
            end
         end
         HOLD: begin
            if (w_tick) begin
               if (r_hold == HOLD_LAST) begin
                  w_done_nx = 1'b1;
                  w_hold_nx = '0;
                  if (repeat_en) begin
                     w_p_nx     = 4'd0;
                     w_state_nx = SCROLL;
                  end else begin
                     w_state_nx = SHOW;
                  end
               end else begin
                  w_hold_nx = r_hold + HW'(1);
               end
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   // State register; busy and done update on the same edge as the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_p     <= 4'd0;
         r_hold  <= '0;
         r_data  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_p     <= w_p_nx;
         r_hold  <= w_hold_nx;
         r_data  <= w_data_nx;
         busy    <= (w_state_nx == SCROLL) || (w_state_nx == HOLD);
         done    <= w_done_nx;
      end
   end

   // Display registers follow the current state one cycle later.
   always_ff @(posedge clk) begin
      if (reset) begin
         d3 <= BLANK;
         d2 <= BLANK;
         d1 <= BLANK;
         d0 <= BLANK;
         dp <= 4'b0000;
      end else begin
         case (r_state)
            IDLE: begin
               d3 <= SEG_G;
               d2 <= SEG_G;
               d1 <= SEG_G;
               d0 <= SEG_G;
               dp <= 4'b0000;
            end
            SHOW: begin
               d3 <= sym(r_data, r_p);
               d2 <= sym(r_data, r_p + 4'd1);
               d1 <= sym(r_data, r_p + 4'd2);
               d0 <= sym(r_data, r_p + 4'd3);
               dp <= 4'b0001;
            end
            default: begin
               d3 <= sym(r_data, r_p);
               d2 <= sym(r_data, r_p + 4'd1);
               d1 <= sym(r_data, r_p + 4'd2);
               d0 <= sym(r_data, r_p + 4'd3);
               dp <= 4'b0000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hex_scroller.sv
// Self-checking bench for hex_scroller with short ticks and a two-tick hold.
module tb_hex_scroller;

   localparam int HOLD  = 2;
   localparam int TICK  = 4;
   localparam int TPASS = TICK * (8 + HOLD);

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data_in;
   logic        load;
   logic        repeat_en;
   logic        busy;
   logic        done;
   logic [4:0]  d3, d2, d1, d0;
   logic [3:0]  dp;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] m_data;
   logic [31:0] m_prev_data;
   bit          m_prev_show;
   int          m_stop;

   always #5 clk = ~clk;

   hex_scroller #(.SIMULATE(1), .HOLD_TICKS(HOLD)) dut (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .load      (load),
      .repeat_en (repeat_en),
      .busy      (busy),
      .done      (done),
      .d3        (d3),
      .d2        (d2),
      .d1        (d1),
      .d0        (d0),
      .dp        (dp)
   );

   // Symbol i of the scroll sequence for word w.
   function automatic int sym(logic [31:0] w, int i);
      if (i < 4) return 23;
      return int'((w >> (4 * (11 - i))) & 32'hF);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(string tag, int e3, int e2, int e1, int e0, int edp, int ebusy, int edone);
      chk({tag, ".d3"}, 32'(d3), 32'(e3));
      chk({tag, ".d2"}, 32'(d2), 32'(e2));
      chk({tag, ".d1"}, 32'(d1), 32'(e1));
      chk({tag, ".d0"}, 32'(d0), 32'(e0));
      chk({tag, ".dp"}, 32'(dp), 32'(edp));
      chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
      chk({tag, ".done"}, 32'(done), 32'(edone));
   endtask

   // Expected outputs t edges after the accepting edge of the current load.
   task automatic check_model(string tag, int t);
      int p, s, edp, ebusy, edone;
      logic [31:0] w;
      bit idle_pat;
      idle_pat = 1'b0;
      w = m_data;
      if (t == 0) begin
         if (m_prev_show) begin
            w = m_prev_data; p = 8; edp = 1;
         end else begin
            idle_pat = 1'b1; p = 0; edp = 0;
         end
      end else begin
         s = t - 1;
         if (s >= m_stop) begin
            p = 8; edp = 1;
         end else begin
            p = (s / TICK) % (8 + HOLD);
            if (p > 8) p = 8;
            edp = 0;
         end
      end
      ebusy = (t < m_stop) ? 1 : 0;
      edone = (t > 0 && (t % TPASS) == 0 && t <= m_stop) ? 1 : 0;
      if (idle_pat)
         chk_all($sformatf("%s.t%0d", tag, t), 22, 22, 22, 22, 0, ebusy, edone);
      else
         chk_all($sformatf("%s.t%0d", tag, t), sym(w, p), sym(w, p + 1), sym(w, p + 2),
                 sym(w, p + 3), edp, ebusy, edone);
   endtask

   // Load w, run for passes, optionally attempt a second load while busy at glitch_t.
   task automatic load_and_run(string tag, logic [31:0] w, int passes, int t_end,
                               int glitch_t, logic [31:0] glitch_w);
      data_in = w;
      load    = 1'b1;
      step();
      load    = 1'b0;
      data_in = $urandom;
      m_data  = w;
      m_stop  = TPASS * passes;
      for (int t = 0; t <= t_end; t++) begin
         check_model(tag, t);
         if (((t + 1) % TPASS) == 0) repeat_en = ((t + 1) < m_stop);
         else repeat_en = 1'($urandom);
         if (t == glitch_t) begin
            load = 1'b1; data_in = glitch_w;
         end else begin
            load = 1'b0; data_in = $urandom;
         end
         step();
      end
      load        = 1'b0;
      m_prev_show = 1'b1;
      m_prev_data = w;
   endtask

   initial begin
      reset     = 1'b1;
      load      = 1'b0;
      repeat_en = 1'b0;
      data_in   = '0;
      m_prev_show = 1'b0;
      m_prev_data = '0;
      m_data      = '0;
      m_stop      = 0;

      step();
      step();
      chk_all("in_reset", 23, 23, 23, 23, 0, 0, 0);
      reset = 1'b0;
      step();
      chk_all("idle", 22, 22, 22, 22, 0, 0, 0);
      step();
      chk_all("idle2", 22, 22, 22, 22, 0, 0, 0);

      load_and_run("scroll12345678", 32'h1234_5678, 1, 45, -1, 32'h0);
      chk_all("show5678", 5, 6, 7, 8, 1, 0, 0);

      load_and_run("busy_drop", 32'h0000_000F, 1, 45, 10, 32'hDEAD_BEEF);
      chk_all("show000F", 0, 0, 0, 15, 1, 0, 0);

      for (int k = 0; k < 3; k++)
         load_and_run($sformatf("rand%0d", k), $urandom, 1, 42,
                      int'($urandom_range(0, 37)), $urandom);

      load_and_run("repeatA5", 32'hA5A5_A5A5, 3, 125, -1, 32'h0);

      // Abort a scroll with reset just after its fifth tick.
      data_in = $urandom;
      m_data  = data_in;
      m_stop  = TPASS;
      load    = 1'b1;
      step();
      load    = 1'b0;
      for (int t = 0; t <= 21; t++) begin
         check_model("abort", t);
         repeat_en = 1'($urandom);
         step();
      end
      reset = 1'b1;
      step();
      chk_all("abort_rst", 23, 23, 23, 23, 0, 0, 0);
      reset = 1'b0;
      step();
      chk_all("abort_idle", 22, 22, 22, 22, 0, 0, 0);
      m_prev_show = 1'b0;

      load_and_run("after_abort", $urandom, 1, 42, -1, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hex_scroller.md
HEX_SCROLLER -- requirements
Module: hex_scroller

Interface
REQ-001 Parameter SIMULATE, default 0, selects short tick period for simulation (1) or hardware period (0).
REQ-002 Parameter HOLD_TICKS, default 4, number of ticks the final window is held before completion.
REQ-003 clk  input  1  100 MHz system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_in  input  32  word to display, 8 hex nibbles, nibble 7 shown first.
REQ-006 load  input  1  request to start a scroll of data_in.
REQ-007 repeat_en  input  1  when high, restart the scroll after the hold instead of stopping.
REQ-008 busy  output  1  high while scrolling or holding; load ignored while high.
REQ-009 done  output  1  one-cycle pulse on completion of each scroll-plus-hold pass.
REQ-010 d3, d2, d1, d0  output  5 each  digit codes for the display controller; d3 is leftmost, codes 0-15 hex, 22 segment g, 23 blank.
REQ-011 dp  output  4  decimal-point enables, bit i for digit i, active-high.

Function
REQ-012 Tick period TICK_CNT SHALL be 25_000_000 cycles (4 Hz) when SIMULATE=0 and 4 cycles when SIMULATE=1.
REQ-013 Tick counter SHALL run only in SCROLL and HOLD, clear on load acceptance, and pulse tick when count equals TICK_CNT-1, then wrap to 0.
REQ-014 States SHALL be IDLE, SCROLL, HOLD, SHOW.
REQ-015 Load SHALL be accepted when load=1 and the state is IDLE or SHOW; on acceptance, capture data_in, set position p=0, go to SCROLL.
REQ-016 Symbol sequence S[0..11] = blank x4, then nibble 7 down to nibble 0; window at p drives d3=S[p], d2=S[p+1], d1=S[p+2], d0=S[p+3].
REQ-017 In SCROLL each tick SHALL increment p; when a tick occurs at p=7, p becomes 8 and the state becomes HOLD with the hold count cleared.
REQ-018 In HOLD, the window stays at p=8; on the HOLD_TICKS-th tick, pulse done and go to SCROLL with p=0 if repeat_en=1, else go to SHOW.
REQ-019 SHOW SHALL display window p=8 with dp=4'b0001 until a new load is accepted.
REQ-020 IDLE SHALL display code 22 on all four digits with dp=4'b0000.
REQ-021 dp SHALL be 4'b0000 in SCROLL and HOLD.
REQ-022 All outputs SHALL be registered; a state or p change at edge k appears on the d outputs at edge k+1.
REQ-023 busy SHALL be high exactly in SCROLL and HOLD, registered with the state.
REQ-024 Load asserted while busy SHALL be dropped, not queued; captured data is unchanged.
REQ-025 If a load is accepted in the same cycle that done is pulsed, done is not produced; acceptance is impossible in HOLD, so this case SHALL not arise.
REQ-026 repeat_en SHALL be sampled only on the final HOLD tick.

Reset
REQ-027 Reset SHALL force state IDLE, p=0, tick and hold counts 0, captured data 0, busy=0, done=0, d3..d0=23, dp=4'b0000; the IDLE pattern appears on the first cycle after reset deasserts.
REQ-028 Reset asserted mid-scroll or mid-hold SHALL abort without a done pulse.

Structure
REQ-029 A shared package SHALL hold the digit code constants (BLANK=23, SEG_G=22), the state enumeration, and the tick-period constants for both modes.
REQ-030 Tick generation SHALL be a sub-module tick_gen with enable, clear and tick ports, parameterised by period.

Verification (SIMULATE=1, HOLD_TICKS=2)
REQ-031 Reset, then idle -> d3..d0 = 22,22,22,22 and busy=0 on the first cycle after reset.
REQ-032 Load 0x12345678 -> next cycle all 23 and busy=1; after 4 ticks (16 cycles), digits are 1,2,3,4; after 8 ticks, digits are 5,6,7,8.
REQ-033 Continue REQ-032 with repeat_en=0 -> done pulses once on the 10th tick, then SHOW state with 5,6,7,8, dp=0001, and busy=0.
REQ-034 Load 0xDEADBEEF while busy from an earlier load of 0x0000000F -> second load ignored; final window shows 0,0,0,F.
REQ-035 repeat_en=1 with 0xA5A5A5A5 -> done every 10 ticks, and the window returns to all 23 on the cycle after each done.
REQ-036 Assert reset at tick 5 of a scroll -> no done; the next cycle shows 22 x4 with busy=0.
